// File: rtl/bnn_pkg.sv
// Shared types and helpers for the time-multiplexed binary neural network engine:
// sequencer state encoding, threshold/store width helpers and a popcount.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HID  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Widest vector the popcount helper accepts; neuron fan-in must not exceed it.
  localparam int POP_MAX = 64;

  // Threshold width for a neuron with n inputs: must hold 0..n+1.
  function automatic int tw_of(input int n);
    return $clog2(n + 32'sd2);
  endfunction

  // Total parameter store length for the two-layer network.
  function automatic int p_bits_of(input int n_in, input int n_hid, input int n_out);
    return n_hid * (n_in + tw_of(n_in)) + n_out * (n_hid + tw_of(n_hid));
  endfunction

  // Number of set bits in a (zero-padded) vector.
  function automatic logic [7:0] popcount(input logic [POP_MAX-1:0] v);
    logic [7:0] c;
    c = 8'd0;
    for (int i = 32'sd0; i < POP_MAX; i++) begin
      c = c + {7'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/bnn_xnor_neuron.sv
// Combinational binary neuron: XNOR the input with the weights, count the
// matches and compare against an unsigned threshold. Also reports the signed
// margin (matches - threshold) for the output-layer argmax.
module bnn_xnor_neuron
  import bnn_pkg::*;
#(
  parameter int N  = 8,
  parameter int TW = 4
) (
  input  logic [N-1:0]         in_v,
  input  logic [N-1:0]         w,
  input  logic [TW-1:0]        thr,
  output logic                 fire,
  output logic signed [TW:0]   margin
);

  logic [POP_MAX-1:0] match_s;
  logic [7:0]         pop_s;
  logic [TW:0]        pop_ext_s;
  logic [TW:0]        thr_ext_s;

  // Match count and threshold comparison; the count never exceeds N, which fits in TW bits
  always_comb begin
    match_s          = '0;
    match_s[N-1:0]   = ~(in_v ^ w);
    pop_s            = popcount(match_s);
    pop_ext_s        = pop_s[TW:0];
    thr_ext_s        = {1'b0, thr};
    fire             = (pop_ext_s >= thr_ext_s);
    margin           = $signed(pop_ext_s) - $signed(thr_ext_s);
  end

endmodule

// File: rtl/bnn_seq_engine.sv
// Two-layer binary neural network evaluated one neuron per cycle.
// Hidden layer first (counter k), then output layer (counter m), from a
// serially loaded parameter store that can be daisy-chained via param_out.
// Optional feature macro: BNN_ARGMAX_EN adds out_class, the index of the
// output neuron with the largest signed margin (lowest index on ties).
module bnn_seq_engine
  import bnn_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int N_HID = 16,
  parameter int N_OUT = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      param_shift,
  input  logic                      param_in,
  output logic                      param_out,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN-1:0]           x,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_OUT-1:0]          y,
`ifdef BNN_ARGMAX_EN
  output logic [$clog2(N_OUT)-1:0]  out_class,
`endif
  output logic                      busy
);

  localparam int TWH      = tw_of(N_IN);
  localparam int TWO      = tw_of(N_HID);
  localparam int WH       = N_IN + TWH;
  localparam int WO       = N_HID + TWO;
  localparam int OUT_BASE = N_HID * WH;
  localparam int P_BITS   = p_bits_of(N_IN, N_HID, N_OUT);
  localparam int CW       = $clog2((N_HID > N_OUT) ? N_HID : N_OUT);
  localparam logic [CW-1:0] LAST_HID = CW'(N_HID - 32'sd1);
  localparam logic [CW-1:0] LAST_OUT = CW'(N_OUT - 32'sd1);

  state_e              state_r, state_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic                shift_s, accept_s;
  logic [P_BITS-1:0]   store_r;
  logic [N_IN-1:0]     x_r;
  logic [N_HID-1:0]    hidden_r, hidden_s;
  logic [N_OUT-1:0]    y_acc_r, y_acc_s;
  logic [N_OUT-1:0]    y_r;
  logic                out_valid_r;

  logic [WH-1:0]       hid_word_s;
  logic [WO-1:0]       out_word_s;
  logic                hid_fire_s, out_fire_s;
  logic signed [TWH:0] hid_margin_s;
  logic signed [TWO:0] out_margin_s;
  logic                unused_hid_margin_s;

  // Word selection: the neuron counter picks the active neuron in each layer
  always_comb begin
    hid_word_s = store_r[int'(cnt_r) * WH +: WH];
    out_word_s = store_r[OUT_BASE + int'(cnt_r) * WO +: WO];
  end

  bnn_xnor_neuron #(.N(N_IN), .TW(TWH)) u_hid_neuron (
    .in_v   (x_r),
    .w      (hid_word_s[N_IN-1:0]),
    .thr    (hid_word_s[WH-1:N_IN]),
    .fire   (hid_fire_s),
    .margin (hid_margin_s)
  );

  bnn_xnor_neuron #(.N(N_HID), .TW(TWO)) u_out_neuron (
    .in_v   (hidden_r),
    .w      (out_word_s[N_HID-1:0]),
    .thr    (out_word_s[WO-1:N_HID]),
    .fire   (out_fire_s),
    .margin (out_margin_s)
  );

  // Hidden-layer margin has no consumer
  assign unused_hid_margin_s = ^hid_margin_s;

  // Next-state, counter and control strobes for the layer sequencer
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    shift_s  = 1'b0;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = '0;
        if (param_shift) begin
          shift_s = 1'b1;
        end else if (in_valid) begin
          accept_s = 1'b1;
          state_s  = HID;
        end else begin
          state_s = IDLE;
        end
      end
      HID: begin
        if (cnt_r == LAST_HID) begin
          state_s = OUT;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CW'(32'd1);
        end
      end
      OUT: begin
        if (cnt_r == LAST_OUT) begin
          state_s = DONE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CW'(32'd1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Sequencer state and neuron counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Insert the current neuron's result into the hidden vector or the output accumulator
  always_comb begin
    hidden_s = hidden_r;
    y_acc_s  = y_acc_r;
    for (int k = 32'sd0; k < N_HID; k++) begin
      if (cnt_r == CW'(k)) begin
        hidden_s[k] = hid_fire_s;
      end else begin
        hidden_s[k] = hidden_r[k];
      end
    end
    for (int m = 32'sd0; m < N_OUT; m++) begin
      if (cnt_r == CW'(m)) begin
        y_acc_s[m] = out_fire_s;
      end else begin
        y_acc_s[m] = y_acc_r[m];
      end
    end
  end

  // Parameter store, latched sample, layer vectors and the held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_r     <= '0;
      x_r         <= '0;
      hidden_r    <= '0;
      y_acc_r     <= '0;
      y_r         <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (shift_s) begin
        store_r <= {store_r[P_BITS-2:0], param_in};
      end
      if (accept_s) begin
        x_r <= x;
      end
      if (state_r == HID) begin
        hidden_r <= hidden_s;
      end
      if (state_r == OUT) begin
        y_acc_r <= y_acc_s;
        if (cnt_r == LAST_OUT) begin
          y_r         <= y_acc_s;
          out_valid_r <= 1'b1;
        end
      end
      if ((state_r == DONE) && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

`ifdef BNN_ARGMAX_EN
  localparam int CLW = $clog2(N_OUT);

  logic signed [TWO:0] best_margin_r, best_margin_s;
  logic [CLW-1:0]      best_idx_r, best_idx_s;
  logic [CLW-1:0]      out_class_r;

  // Running maximum; strict greater-than keeps the lowest index on ties
  always_comb begin
    if ((cnt_r == '0) || (out_margin_s > best_margin_r)) begin
      best_margin_s = out_margin_s;
      best_idx_s    = CLW'(cnt_r);
    end else begin
      best_margin_s = best_margin_r;
      best_idx_s    = best_idx_r;
    end
  end

  // Argmax tracking during the output layer; the class is published with the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_margin_r <= '0;
      best_idx_r    <= '0;
      out_class_r   <= '0;
    end else if (state_r == OUT) begin
      best_margin_r <= best_margin_s;
      best_idx_r    <= best_idx_s;
      if (cnt_r == LAST_OUT) begin
        out_class_r <= best_idx_s;
      end
    end
  end

  assign out_class = out_class_r;
`else
  logic unused_out_margin_s;
  assign unused_out_margin_s = ^out_margin_s;
`endif

  assign param_out = store_r[P_BITS-1];
  assign in_ready  = (state_r == IDLE) & ~param_shift;
  assign busy      = (state_r != IDLE);
  assign out_valid = out_valid_r;
  assign y         = y_r;

endmodule

// File: tb/tb_bnn_seq_engine.sv
// Self-checking bench for bnn_seq_engine: a behavioural model (store as a
// bit vector, network evaluated with plain loops, run timing as a countdown)
// is compared against the DUT every cycle, plus directed literal checks.
// Honours BNN_ARGMAX_EN when defined.
module tb_bnn_seq_engine;

  localparam int N_IN  = 8;
  localparam int N_HID = 16;
  localparam int N_OUT = 8;
  localparam int TWH   = $clog2(N_IN + 2);
  localparam int TWO   = $clog2(N_HID + 2);
  localparam int WH    = N_IN + TWH;
  localparam int WO    = N_HID + TWO;
  localparam int P     = N_HID * WH + N_OUT * WO;
  localparam int RUN   = N_HID + N_OUT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic param_shift = 1'b0;
  logic param_in = 1'b0;
  logic param_out;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [N_IN-1:0] x = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [N_OUT-1:0] y;
  logic busy;
`ifdef BNN_ARGMAX_EN
  logic [$clog2(N_OUT)-1:0] out_class;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  bnn_seq_engine #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .param_shift (param_shift),
    .param_in    (param_in),
    .param_out   (param_out),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .y           (y),
`ifdef BNN_ARGMAX_EN
    .out_class   (out_class),
`endif
    .busy        (busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int field(input logic [P-1:0] st, input int lo, input int n);
    int v = 0;
    for (int b = 0; b < n; b++) if (st[lo + b]) v += (1 << b);
    return v;
  endfunction

  function automatic logic [N_HID-1:0] hid_of(input logic [N_IN-1:0] xv, input logic [P-1:0] st);
    logic [N_HID-1:0] h;
    int pc;
    for (int k = 0; k < N_HID; k++) begin
      pc = 0;
      for (int j = 0; j < N_IN; j++) if (xv[j] == st[k*WH + j]) pc++;
      h[k] = (pc >= field(st, k*WH + N_IN, TWH));
    end
    return h;
  endfunction

  function automatic int out_margin(input logic [N_HID-1:0] h, input logic [P-1:0] st, input int m);
    int pc = 0;
    int base = N_HID*WH + m*WO;
    for (int j = 0; j < N_HID; j++) if (h[j] == st[base + j]) pc++;
    return pc - field(st, base + N_HID, TWO);
  endfunction

  function automatic logic [N_OUT-1:0] eval_y(input logic [N_IN-1:0] xv, input logic [P-1:0] st);
    logic [N_OUT-1:0] r;
    logic [N_HID-1:0] h = hid_of(xv, st);
    for (int m = 0; m < N_OUT; m++) r[m] = (out_margin(h, st, m) >= 0);
    return r;
  endfunction

  function automatic int eval_cls(input logic [N_IN-1:0] xv, input logic [P-1:0] st);
    logic [N_HID-1:0] h = hid_of(xv, st);
    int best = -1000;
    int cls = 0;
    for (int m = 0; m < N_OUT; m++) begin
      if (out_margin(h, st, m) > best) begin
        best = out_margin(h, st, m);
        cls = m;
      end
    end
    return cls;
  endfunction

  logic [P-1:0]     m_store;
  int               m_phase;   // 0 idle, 1 running, 2 result held
  int               m_cnt;
  logic             m_valid;
  logic [N_OUT-1:0] m_y, m_pend;
  int               m_cls, m_pcls;

  // Model: cycle-level view of the engine as idle / countdown / result-held
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_store <= '0; m_phase <= 0; m_cnt <= 0; m_valid <= 1'b0;
      m_y <= '0; m_pend <= '0; m_cls <= 0; m_pcls <= 0;
    end else begin
      case (m_phase)
        0: begin
          if (param_shift) m_store <= {m_store[P-2:0], param_in};
          else if (in_valid) begin
            m_pend  <= eval_y(x, m_store);
            m_pcls  <= eval_cls(x, m_store);
            m_cnt   <= RUN;
            m_phase <= 1;
          end
        end
        1: begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) begin
            m_phase <= 2; m_valid <= 1'b1; m_y <= m_pend; m_cls <= m_pcls;
          end
        end
        default: begin
          if (out_ready) begin m_phase <= 0; m_valid <= 1'b0; end
        end
      endcase
    end
  end

  // Compare process: every cycle once reset has been applied
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("y", {24'd0, y}, {24'd0, m_y});
      check("busy", {31'd0, busy}, {31'd0, (m_phase != 0)});
      check("in_ready", {31'd0, in_ready}, {31'd0, (m_phase == 0) && !param_shift});
      check("param_out", {31'd0, param_out}, {31'd0, m_store[P-1]});
`ifdef BNN_ARGMAX_EN
      if (m_valid) check("out_class", {29'd0, out_class}, m_cls);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [N_IN-1:0]  hw[N_HID];
  int               ht[N_HID];
  logic [N_HID-1:0] ow[N_OUT];
  int               ot[N_OUT];

  function automatic logic [P-1:0] build_image();
    logic [P-1:0] img = '0;
    for (int k = 0; k < N_HID; k++) img[k*WH +: WH] = {TWH'(ht[k]), hw[k]};
    for (int m = 0; m < N_OUT; m++) img[N_HID*WH + m*WO +: WO] = {TWO'(ot[m]), ow[m]};
    return img;
  endfunction

  task automatic load_image(input logic [P-1:0] img);
    for (int i = P - 1; i >= 0; i--) begin
      @(posedge clk); #1;
      param_shift = 1'b1;
      param_in = img[i];
    end
    @(posedge clk); #1;
    param_shift = 1'b0;
  endtask

  task automatic run_one(input logic [N_IN-1:0] xv, input int hold, input bit lit,
                         input logic [N_OUT-1:0] ey, input string nm);
    int cyc;
    @(posedge clk); #1;
    x = xv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, "_latency"}, cyc, RUN);
    if (lit) check(nm, {24'd0, y}, {24'd0, ey});
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [P-1:0] img_t;

  initial begin
    // reset
    repeat (1) @(posedge clk);
    #1 chk_en = 1'b1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", {24'd0, y}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_param_out", {31'd0, param_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // pin the model with hand-computed values
    check("model_zero_store", {24'd0, eval_y(8'hA5, '0)}, 32'h0000_00FF);

    // test 1: empty store, all thresholds zero
    run_one(8'hA5, 0, 1'b1, 8'hFF, "t1_y");

    // test 2: never-firing thresholds, zero weights
    for (int k = 0; k < N_HID; k++) begin hw[k] = '0; ht[k] = N_IN + 1; end
    for (int m = 0; m < N_OUT; m++) begin ow[m] = '0; ot[m] = N_HID + 1; end
    img_t = build_image();
    load_image(img_t);
    check("t2_param_out_first_bit", {31'd0, param_out}, 32'd1);
    run_one(8'h3C, 2, 1'b1, 8'h00, "t2_y");
    @(posedge clk); #1 param_shift = 1'b1; param_in = 1'b0;
    @(posedge clk); #1 param_shift = 1'b0;
    check("t2_param_out_second_bit", {31'd0, param_out}, 32'd0);

    // test 3: AND-of-all network
    for (int k = 0; k < N_HID; k++) begin hw[k] = 8'hFF; ht[k] = 8; end
    for (int m = 0; m < N_OUT; m++) begin ow[m] = 16'hFFFF; ot[m] = 16; end
    img_t = build_image();
    load_image(img_t);
    check("model_and_ff", {24'd0, eval_y(8'hFF, img_t)}, 32'h0000_00FF);
    check("model_and_fe", {24'd0, eval_y(8'hFE, img_t)}, 32'h0000_0000);
    run_one(8'hFE, 0, 1'b1, 8'h00, "t3_y_fe");

    // test 4: back-pressure in DONE with shift attempts
    @(posedge clk); #1 x = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (RUN) begin @(posedge clk); #1; end
    check("t3_y_ff", {24'd0, y}, 32'h0000_00FF);
    for (int c = 0; c < 10; c++) begin
      param_shift = 1'($urandom); param_in = 1'($urandom);
      @(posedge clk); #1;
      check("t4_y_hold", {24'd0, y}, 32'h0000_00FF);
      check("t4_valid_hold", {31'd0, out_valid}, 32'd1);
      check("t4_in_ready", {31'd0, in_ready}, 32'd0);
    end
    param_shift = 1'b0;
    check("t4_store_kept", {31'd0, param_out}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;

    // test 5: reset in the middle of the hidden layer
    @(posedge clk); #1 x = 8'h00; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_y", {24'd0, y}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_param_out", {31'd0, param_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_one(8'hA5, 0, 1'b1, 8'hFF, "t5_fresh_y");

`ifdef BNN_ARGMAX_EN
    // test 6: tie between outputs 2 and 5 at margin 9
    for (int k = 0; k < N_HID; k++) begin hw[k] = '0; ht[k] = 0; end
    for (int m = 0; m < N_OUT; m++) begin ow[m] = '0; ot[m] = 0; end
    ow[2] = 16'hFFFF; ot[2] = 7;
    ow[5] = 16'hFFFF; ot[5] = 7;
    img_t = build_image();
    check("model_argmax", eval_cls(8'h5A, img_t), 32'd2);
    load_image(img_t);
    @(posedge clk); #1 x = 8'h5A; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (RUN) begin @(posedge clk); #1; end
    check("t6_out_class", {29'd0, out_class}, 32'd2);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
`endif

    // randomized parameters and directed runs
    for (int k = 0; k < N_HID; k++) begin hw[k] = N_IN'($urandom); ht[k] = $urandom_range(0, N_IN + 1); end
    for (int m = 0; m < N_OUT; m++) begin ow[m] = N_HID'($urandom); ot[m] = $urandom_range(0, N_HID + 1); end
    load_image(build_image());
    for (int r = 0; r < 6; r++) run_one(N_IN'($urandom), $urandom_range(0, 3), 1'b0, 8'h00, "rnd_run");

    // fully random interleaving of shifts, samples and back-pressure
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      param_shift = ($urandom_range(0, 7) == 0);
      param_in    = 1'($urandom);
      in_valid    = 1'($urandom);
      x           = N_IN'($urandom);
      out_ready   = ($urandom_range(0, 2) == 0);
    end
    param_shift = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 60 && busy; c++) begin @(posedge clk); #1; end
    check("drain_idle", {31'd0, busy}, 32'd0);
    out_ready = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
